// File: rtl/fsm_umbrales_param_pkg.sv
// Shared definitions for the threshold/pause flow-control FSM: state encoding
// and default threshold values.
package fsm_umbrales_param_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int unsigned DEF_UMBRAL_ALTO = 6;
  localparam int unsigned DEF_UMBRAL_BAJO = 2;

endpackage

// File: rtl/fsm_umbrales_param_umbral_histeresis.sv
// Per-FIFO pause flag with hysteresis: set at/above the high threshold,
// cleared at/below the low threshold, held in between; forced low when disabled.
module umbral_histeresis #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          i_en,
  input  logic [LW-1:0] i_level,
  input  logic [LW-1:0] i_alto,
  input  logic [LW-1:0] i_bajo,
  output logic          o_pause
);

  logic r_pause;
  logic w_set;
  logic w_clr;

  assign w_set = (i_level >= i_alto);
  assign w_clr = (i_level <= i_bajo);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_pause <= 1'b0;
    end else if (!i_en) begin
      r_pause <= 1'b0;
    end else if (w_set) begin
      r_pause <= 1'b1;
    end else if (w_clr) begin
      r_pause <= 1'b0;
    end
  end

  assign o_pause = r_pause;

endmodule

// File: rtl/fsm_umbrales_param.sv
// Flow-control FSM for N monitored FIFOs: latches thresholds in INIT, tracks
// idle/active, records sticky overflows and drives per-FIFO pause flags.
module fsm_umbrales_param
  import fsm_umbrales_param_pkg::*;
#(
  parameter int N_FIFO = 5,
  parameter int LW     = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [N_FIFO*LW-1:0] umbral_alto_in,
  input  logic [N_FIFO*LW-1:0] umbral_bajo_in,
  input  logic [N_FIFO*LW-1:0] fifo_level,
  input  logic [N_FIFO-1:0]    fifo_empty,
  input  logic [N_FIFO-1:0]    fifo_full,
  input  logic [N_FIFO-1:0]    fifo_wr,
  output logic [N_FIFO*LW-1:0] umbral_alto_out,
  output logic [N_FIFO*LW-1:0] umbral_bajo_out,
  output logic [N_FIFO-1:0]    pause,
  output logic [N_FIFO-1:0]    error_full,
  output logic                 init_out,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic                 cfg_invalid
);

  state_t                r_state;
  state_t                w_next;
  logic [N_FIFO*LW-1:0]  r_alto;
  logic [N_FIFO*LW-1:0]  r_bajo;
  logic [N_FIFO-1:0]     r_error_full;
  logic                  r_cfg_invalid;
  logic [N_FIFO-1:0]     w_ovf;
  logic                  w_cfg_valid;
  logic                  w_pause_en;

  assign w_ovf = fifo_wr & fifo_full;

  always_comb begin
    w_cfg_valid = 1'b1;
    for (int unsigned i = 0; i < N_FIFO; i++) begin
      if (umbral_bajo_in[i*LW +: LW] >= umbral_alto_in[i*LW +: LW]) begin
        w_cfg_valid = 1'b0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RESET: w_next = ST_INIT;
      ST_INIT: begin
        if (!init && w_cfg_valid) w_next = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (|w_ovf)           w_next = ST_ERROR;
        else if (init)        w_next = ST_INIT;
        else if (&fifo_empty) w_next = ST_IDLE;
        else                  w_next = ST_ACTIVE;
      end
      ST_ERROR: begin
        if (init) w_next = ST_INIT;
      end
      default: w_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state       <= ST_RESET;
      r_alto        <= '0;
      r_bajo        <= '0;
      r_error_full  <= '0;
      r_cfg_invalid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT) begin
        r_alto <= umbral_alto_in;
        r_bajo <= umbral_bajo_in;
        if (w_cfg_valid)  r_cfg_invalid <= 1'b0;
        else if (!init)   r_cfg_invalid <= 1'b1;
      end else begin
        r_cfg_invalid <= 1'b0;
      end
      // Entering INIT wipes the sticky bits; otherwise any post-config state accumulates.
      if (w_next == ST_INIT) begin
        r_error_full <= '0;
      end else if (r_state == ST_IDLE || r_state == ST_ACTIVE || r_state == ST_ERROR) begin
        r_error_full <= r_error_full | w_ovf;
      end
    end
  end

  // Pause only evaluates across edges that stay inside IDLE/ACTIVE, so it drops
  // on the very edge that leaves for INIT or ERROR.
  assign w_pause_en = (r_state == ST_IDLE || r_state == ST_ACTIVE) &&
                      (w_next  == ST_IDLE || w_next  == ST_ACTIVE);

  for (genvar g = 0; g < N_FIFO; g++) begin : g_hist
    umbral_histeresis #(.LW(LW)) u_hist (
      .clk     (clk),
      .reset_L (reset_L),
      .i_en    (w_pause_en),
      .i_level (fifo_level[g*LW +: LW]),
      .i_alto  (r_alto[g*LW +: LW]),
      .i_bajo  (r_bajo[g*LW +: LW]),
      .o_pause (pause[g])
    );
  end

  assign umbral_alto_out = r_alto;
  assign umbral_bajo_out = r_bajo;
  assign error_full      = r_error_full;
  assign cfg_invalid     = r_cfg_invalid;
  assign init_out        = (r_state == ST_INIT);
  assign idle_out        = (r_state == ST_IDLE);
  assign active_out      = (r_state == ST_ACTIVE);
  assign error_out       = (r_state == ST_ERROR);

endmodule

// File: tb/tb_fsm_umbrales_param.sv
// Self-checking bench for fsm_umbrales_param: directed scenarios plus a
// randomized run compared against a behavioural model of the flow-control rules.
module tb_fsm_umbrales_param;
  import fsm_umbrales_param_pkg::*;

  localparam int N  = 5;
  localparam int LW = 4;

  localparam int M_RESET  = 0;
  localparam int M_INIT   = 1;
  localparam int M_IDLE   = 2;
  localparam int M_ACTIVE = 3;
  localparam int M_ERROR  = 4;

  logic            clk = 1'b0;
  logic            reset_L;
  logic            init;
  logic [N*LW-1:0] umbral_alto_in;
  logic [N*LW-1:0] umbral_bajo_in;
  logic [N*LW-1:0] fifo_level;
  logic [N-1:0]    fifo_empty;
  logic [N-1:0]    fifo_full;
  logic [N-1:0]    fifo_wr;
  logic [N*LW-1:0] umbral_alto_out;
  logic [N*LW-1:0] umbral_bajo_out;
  logic [N-1:0]    pause;
  logic [N-1:0]    error_full;
  logic            init_out, idle_out, active_out, error_out, cfg_invalid;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int unsigned m_mode;
  int unsigned m_alto[N];
  int unsigned m_bajo[N];
  bit          m_pause[N];
  bit          m_err[N];
  bit          m_cfg;

  fsm_umbrales_param #(.N_FIFO(N), .LW(LW)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .umbral_alto_in  (umbral_alto_in),
    .umbral_bajo_in  (umbral_bajo_in),
    .fifo_level      (fifo_level),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .fifo_wr         (fifo_wr),
    .umbral_alto_out (umbral_alto_out),
    .umbral_bajo_out (umbral_bajo_out),
    .pause           (pause),
    .error_full      (error_full),
    .init_out        (init_out),
    .idle_out        (idle_out),
    .active_out      (active_out),
    .error_out       (error_out),
    .cfg_invalid     (cfg_invalid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_RESET;
    m_cfg  = 0;
    for (int i = 0; i < N; i++) begin
      m_alto[i] = 0; m_bajo[i] = 0; m_pause[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_edge();
    int unsigned nxt;
    bit valid = 1;
    bit any_ovf = 0;
    bool_loop: for (int i = 0; i < N; i++) begin
      if (umbral_bajo_in[i*LW +: LW] >= umbral_alto_in[i*LW +: LW]) valid = 0;
      if (fifo_wr[i] && fifo_full[i]) any_ovf = 1;
    end
    case (m_mode)
      M_RESET:  nxt = M_INIT;
      M_INIT:   nxt = (!init && valid) ? M_IDLE : M_INIT;
      M_IDLE, M_ACTIVE:
        nxt = any_ovf ? M_ERROR : init ? M_INIT : (&fifo_empty) ? M_IDLE : M_ACTIVE;
      default:  nxt = init ? M_INIT : M_ERROR;
    endcase
    for (int i = 0; i < N; i++) begin
      int unsigned lvl = fifo_level[i*LW +: LW];
      if ((m_mode == M_IDLE || m_mode == M_ACTIVE) && (nxt == M_IDLE || nxt == M_ACTIVE)) begin
        if (lvl >= m_alto[i])      m_pause[i] = 1;
        else if (lvl <= m_bajo[i]) m_pause[i] = 0;
      end else begin
        m_pause[i] = 0;
      end
      if (nxt == M_INIT)     m_err[i] = 0;
      else if (m_mode >= 2)  m_err[i] = m_err[i] | (fifo_wr[i] & fifo_full[i]);
    end
    if (m_mode == M_INIT) begin
      if (valid)      m_cfg = 0;
      else if (!init) m_cfg = 1;
      for (int i = 0; i < N; i++) begin
        m_alto[i] = umbral_alto_in[i*LW +: LW];
        m_bajo[i] = umbral_bajo_in[i*LW +: LW];
      end
    end else begin
      m_cfg = 0;
    end
    m_mode = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_L) model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [N*LW-1:0] exp_alto, exp_bajo;
    reset_L = 0; init = 0; fifo_level = '0; fifo_empty = '1; fifo_full = '0; fifo_wr = '0;
    for (int i = 0; i < N; i++) begin
      umbral_alto_in[i*LW +: LW] = LW'(DEF_UMBRAL_ALTO);
      umbral_bajo_in[i*LW +: LW] = LW'(DEF_UMBRAL_BAJO);
    end
    model_reset();
    tick(); tick();
    checks++;
    if ({umbral_alto_out, umbral_bajo_out, pause, error_full, init_out, idle_out,
         active_out, error_out, cfg_invalid} !== '0) begin
      errors++;
      $display("FAIL reset_zero got alto=%h bajo=%h pause=%b err=%b flags=%b%b%b%b%b exp all 0",
               umbral_alto_out, umbral_bajo_out, pause, error_full,
               init_out, idle_out, active_out, error_out, cfg_invalid);
    end
    reset_L = 1;
    tick();
    checks++;
    if (init_out !== 1'b1 || idle_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_init got init_out=%b idle_out=%b exp 1 0", init_out, idle_out);
    end
    tick();
    exp_alto = 20'h66666; exp_bajo = 20'h22222;
    checks++;
    if (idle_out !== 1'b1 || init_out !== 1'b0) begin
      errors++;
      $display("FAIL init_to_idle got idle_out=%b init_out=%b exp 1 0", idle_out, init_out);
    end
    checks++;
    if (umbral_alto_out !== exp_alto || umbral_bajo_out !== exp_bajo) begin
      errors++;
      $display("FAIL thr_latched got alto=%h bajo=%h exp %h %h",
               umbral_alto_out, umbral_bajo_out, exp_alto, exp_bajo);
    end
  endtask

  task automatic test_invalid_cfg();
    init = 1;
    umbral_bajo_in[2*LW +: LW] = 4'd7;
    umbral_alto_in[2*LW +: LW] = 4'd5;
    tick();
    init = 0;
    tick();
    checks++;
    if (init_out !== 1'b1 || cfg_invalid !== 1'b1) begin
      errors++;
      $display("FAIL cfg_invalid_set got init_out=%b cfg_invalid=%b exp 1 1", init_out, cfg_invalid);
    end
    tick();
    checks++;
    if (init_out !== 1'b1 || cfg_invalid !== 1'b1) begin
      errors++;
      $display("FAIL cfg_invalid_hold got init_out=%b cfg_invalid=%b exp 1 1", init_out, cfg_invalid);
    end
    umbral_bajo_in[2*LW +: LW] = 4'd1;
    tick();
    checks++;
    if (idle_out !== 1'b1 || cfg_invalid !== 1'b0) begin
      errors++;
      $display("FAIL cfg_fixed got idle_out=%b cfg_invalid=%b exp 1 0", idle_out, cfg_invalid);
    end
    checks++;
    if (umbral_alto_out !== 20'h66566 || umbral_bajo_out !== 20'h22122) begin
      errors++;
      $display("FAIL cfg_fixed_thr got alto=%h bajo=%h exp 66566 22122",
               umbral_alto_out, umbral_bajo_out);
    end
  endtask

  task automatic test_activity();
    fifo_empty = 5'b11101;
    tick();
    checks++;
    if (active_out !== 1'b1 || idle_out !== 1'b0) begin
      errors++;
      $display("FAIL go_active got active_out=%b idle_out=%b exp 1 0", active_out, idle_out);
    end
    fifo_empty = 5'b11111;
    tick();
    checks++;
    if (idle_out !== 1'b1 || active_out !== 1'b0) begin
      errors++;
      $display("FAIL go_idle got idle_out=%b active_out=%b exp 1 0", idle_out, active_out);
    end
  endtask

  task automatic test_hysteresis();
    int unsigned levels[6] = '{5, 6, 4, 3, 2, 3};
    bit          exp_p[6]  = '{0, 1, 1, 1, 0, 0};
    for (int k = 0; k < 6; k++) begin
      fifo_level = '0;
      fifo_level[1*LW +: LW] = LW'(levels[k]);
      tick();
      checks++;
      if (pause !== {3'b000, exp_p[k], 1'b0}) begin
        errors++;
        $display("FAIL hyst_step%0d level=%0d got pause=%b exp %b",
                 k, levels[k], pause, {3'b000, exp_p[k], 1'b0});
      end
    end
  endtask

  task automatic test_overflow();
    fifo_empty = 5'b11101;
    tick();
    fifo_full = 5'b10001; fifo_wr = 5'b10001; init = 1;
    tick();
    checks++;
    if (error_out !== 1'b1 || error_full !== 5'b10001) begin
      errors++;
      $display("FAIL ovf_enter got error_out=%b error_full=%b exp 1 10001", error_out, error_full);
    end
    fifo_full = '0; fifo_wr = '0; init = 0;
    tick(); tick();
    checks++;
    if (error_out !== 1'b1 || error_full !== 5'b10001) begin
      errors++;
      $display("FAIL ovf_sticky got error_out=%b error_full=%b exp 1 10001", error_out, error_full);
    end
    fifo_full = 5'b00110; fifo_wr = 5'b00100;
    tick();
    fifo_full = '0; fifo_wr = '0;
    checks++;
    if (error_full !== 5'b10101 || pause !== '0) begin
      errors++;
      $display("FAIL ovf_in_error got error_full=%b pause=%b exp 10101 00000", error_full, pause);
    end
    init = 1;
    tick();
    checks++;
    if (init_out !== 1'b1 || error_full !== '0 || error_out !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got init_out=%b error_full=%b error_out=%b exp 1 00000 0",
               init_out, error_full, error_out);
    end
    init = 0;
    tick();
  endtask

  task automatic test_random();
    logic [N*LW-1:0] e_alto, e_bajo;
    logic [N-1:0]    e_pause, e_err;
    for (int c = 0; c < 400; c++) begin
      init = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++) begin
          int unsigned a = $urandom_range(1, 15);
          umbral_alto_in[i*LW +: LW] = LW'(a);
          umbral_bajo_in[i*LW +: LW] = ($urandom_range(0, 9) == 0) ?
                                       LW'($urandom_range(a, 15)) : LW'($urandom_range(0, a - 1));
        end
      end
      fifo_empty = ($urandom_range(0, 2) == 0) ? '1 : N'($urandom);
      fifo_level = (N*LW)'({$urandom, $urandom});
      fifo_full  = N'($urandom);
      fifo_wr    = ($urandom_range(0, 14) == 0) ? N'($urandom) : '0;
      tick();
      for (int i = 0; i < N; i++) begin
        e_alto[i*LW +: LW] = LW'(m_alto[i]);
        e_bajo[i*LW +: LW] = LW'(m_bajo[i]);
        e_pause[i] = m_pause[i];
        e_err[i]   = m_err[i];
      end
      checks++;
      if (init_out !== (m_mode == M_INIT) || idle_out !== (m_mode == M_IDLE) ||
          active_out !== (m_mode == M_ACTIVE) || error_out !== (m_mode == M_ERROR) ||
          cfg_invalid !== m_cfg) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got i/d/a/e/cfg=%b%b%b%b%b exp mode=%0d cfg=%b",
                 c, init_out, idle_out, active_out, error_out, cfg_invalid, m_mode, m_cfg);
      end
      checks++;
      if (pause !== e_pause || error_full !== e_err) begin
        errors++;
        $display("FAIL rand_flags cyc=%0d got pause=%b err=%b exp %b %b",
                 c, pause, error_full, e_pause, e_err);
      end
      checks++;
      if (umbral_alto_out !== e_alto || umbral_bajo_out !== e_bajo) begin
        errors++;
        $display("FAIL rand_thr cyc=%0d got alto=%h bajo=%h exp %h %h",
                 c, umbral_alto_out, umbral_bajo_out, e_alto, e_bajo);
      end
    end
  endtask

  task automatic test_async_reset();
    init = 1; fifo_wr = '0; fifo_full = '0; fifo_empty = '1; fifo_level = '0;
    for (int i = 0; i < N; i++) begin
      umbral_alto_in[i*LW +: LW] = 4'd6;
      umbral_bajo_in[i*LW +: LW] = 4'd2;
    end
    tick(); tick();
    init = 0;
    tick(); tick();
    fifo_empty = 5'b11101;
    fifo_level[1*LW +: LW] = 4'd7;
    tick();
    checks++;
    if (active_out !== 1'b1 || pause[1] !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got active_out=%b pause=%b exp 1 xxx1x", active_out, pause);
    end
    #3;
    reset_L = 0;
    model_reset();
    #1;
    checks++;
    if ({umbral_alto_out, umbral_bajo_out, pause, error_full, init_out, idle_out,
         active_out, error_out, cfg_invalid} !== '0) begin
      errors++;
      $display("FAIL async_reset got alto=%h bajo=%h pause=%b err=%b flags=%b%b%b%b%b exp all 0",
               umbral_alto_out, umbral_bajo_out, pause, error_full,
               init_out, idle_out, active_out, error_out, cfg_invalid);
    end
  endtask

  initial begin
    test_reset();
    test_invalid_cfg();
    test_activity();
    test_hysteresis();
    test_overflow();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_umbrales_param.md
Name: fsm_umbrales_param

Overview:
- Parametrised flow-control state machine for the PCIe QoS datapath. It watches N FIFOs (Main, VC0..VCn, D0..Dn).
- Holds the programmable high/low thresholds and gives them to the FIFOs.
- Generates per-FIFO pause flags with hysteresis.
- Reports global init/idle/active/error status with a sticky per-FIFO overflow vector.
- Successor of the fixed 5-FIFO state machine: channel count, level width and hysteresis are now generic.

Parameters:
N_FIFO, 5, number of monitored FIFOs
LW, 4, width of each fill level and each threshold (DEPTH+1 representable)

Ports:
clk  input  1  single clock, rising edge
reset_L  input  1  asynchronous active-low reset
init  input  1  request (re)configuration
umbral_alto_in  input  N_FIFO*LW  packed high thresholds, FIFO i at [i*LW +: LW]
umbral_bajo_in  input  N_FIFO*LW  packed low thresholds, same packing
fifo_level  input  N_FIFO*LW  packed current fill levels
fifo_empty  input  N_FIFO  per-FIFO empty
fifo_full  input  N_FIFO  per-FIFO full
fifo_wr  input  N_FIFO  per-FIFO push strobe
umbral_alto_out  output  N_FIFO*LW  latched high thresholds
umbral_bajo_out  output  N_FIFO*LW  latched low thresholds
pause  output  N_FIFO  per-FIFO backpressure flag
error_full  output  N_FIFO  sticky overflow bits
init_out  output  1  state==INIT
idle_out  output  1  state==IDLE
active_out  output  1  state==ACTIVE
error_out  output  1  state==ERROR
cfg_invalid  output  1  thresholds rejected in INIT

Behaviour:
- Reset: clk is the only clock. reset_L is asynchronous, active-low. While reset_L=0 the state is RESET and every output and threshold register is 0.
- States: RESET, INIT, IDLE, ACTIVE, ERROR. Moore machine. The state register and all status outputs are registered, so a change appears 1 cycle after the sampling edge.
- RESET -> INIT on the first rising edge with reset_L=1.
- INIT:
  - Threshold registers load from the *_in buses on every edge.
  - A configuration is valid when umbral_bajo_in[i] < umbral_alto_in[i] for all i.
  - If init=0 and valid -> IDLE.
  - If init=0 and invalid: stay in INIT and set cfg_invalid=1. cfg_invalid clears on the first edge where the configuration is valid.
- IDLE: if &fifo_empty stay; else -> ACTIVE.
- ACTIVE: if &fifo_empty -> IDLE; else stay.
- Overflow event (IDLE/ACTIVE): fifo_wr[i] & fifo_full[i].
  - Any overflow -> ERROR.
  - error_full[i] |= the overflow bit, sticky.
  - Overflow takes priority over init and over the empty-based transitions.
- init=1 in IDLE, ACTIVE or ERROR -> INIT. error_full clears on that edge; pause clears.
- ERROR: held until init or reset. Further overflows still OR into error_full.
- Thresholds: umbral_*_out change only in INIT and are stable in every other state.
- Pause hysteresis, evaluated only in IDLE/ACTIVE (held at 0 in RESET, INIT and ERROR):
  - set pause[i] when fifo_level[i] >= alto[i];
  - clear it when fifo_level[i] <= bajo[i];
  - otherwise hold.
  - Comparisons are unsigned at width LW.
- Edge cases:
  - Level equal to alto and bajo on the same edge cannot occur because bajo<alto is enforced.
  - Simultaneous overflow on several FIFOs sets all corresponding bits in the same cycle.
  - Reset asserted mid-operation forces RESET immediately, asynchronously.
  - Level values greater than the depth are not checked; they are compared as-is.

Decomposition:
- Shared package holds:
  - state encoding: RESET=3'd0, INIT=3'd1, IDLE=3'd2, ACTIVE=3'd3, ERROR=3'd4;
  - default threshold constants.
- One sub-module, umbral_histeresis: per-channel pause flop plus the two comparators. It is instantiated N_FIFO times in a generate loop. The top level holds the FSM, threshold registers and error vector.

Test Plan:
All scenarios use N_FIFO=5, LW=4.
- Reset/config: reset_L low 2 cycles, then high, alto_in=all 4'd6, bajo_in=all 4'd2, init low -> edges go RESET, INIT, IDLE; idle_out=1; umbral_alto_out=20'h66666.
- Invalid config: bajo[2]=4'd7, alto[2]=4'd5 -> stays INIT with cfg_invalid=1; correct bajo[2]=4'd1 -> cfg_invalid=0 and IDLE next edge.
- Activity: fifo_empty=5'b11101 -> active_out=1 one cycle later; back to 5'b11111 -> idle_out=1.
- Hysteresis, FIFO1 with alto=6, bajo=2: level 5,6,4,3,2,3 -> pause[1] = 0,1,1,1,0,0.
- Overflow: fifo_full=5'b10001 with fifo_wr=5'b10001 in ACTIVE -> error_out=1, error_full=5'b10001, persists with inputs cleared; init pulse -> INIT with error_full=0.
- Async reset mid-ACTIVE with pause[1]=1: all outputs 0 immediately, without waiting for a clock edge.
